// File: rtl/key_stream_loader.sv
// key_stream_loader: receives a framed key (KEY_W key bits + 8-bit XOR checksum)
// bit-serially over a valid/ready link, verifies it and commits it onto a
// held-stable parallel key bus. Consecutive checksum failures lead to a
// permanent lockout that only rst_n clears. All outputs are registered.
module key_stream_loader #(
  parameter int KEY_W    = 32,
  parameter int MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             sdata_valid,
  input  logic             sdata,
  output logic             sdata_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_done,
  output logic             load_err,
  output logic             locked_out
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHIFT_KEY  = 3'd1,
    SHIFT_CSUM = 3'd2,
    CHECK      = 3'd3,
    LOCKOUT    = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] LAST_KEY_BIT  = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] LAST_CSUM_BIT = CNT_W'(7);
  localparam logic [CNT_W-1:0] CSUM_FULL     = CNT_W'(8);
  localparam logic [3:0]       FAIL_LIMIT    = 4'(MAX_FAIL);

  state_t             state_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [KEY_W-1:0]   shadow_key_r;
  logic [7:0]         shadow_csum_r;
  logic [3:0]         fail_cnt_r;
  logic               hs_s;
  logic               csum_ok_s;

  // XOR of all bytes of the key; this is the checksum the sender must supply.
  function automatic logic [7:0] key_xor_bytes(input logic [KEY_W-1:0] k);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < KEY_W / 8; i++) begin
      acc = acc ^ k[i*8 +: 8];
    end
    return acc;
  endfunction

  assign hs_s      = sdata_valid & sdata_ready;
  assign csum_ok_s = (shadow_csum_r == key_xor_bytes(shadow_key_r));

  // Frame sequencing, shadow capture, verification and registered outputs.
  // The csum stage waits one extra cycle after its 8th bit (ready already low)
  // before CHECK, giving a two-edge latency from last bit to commit/error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      bit_cnt_r     <= '0;
      shadow_key_r  <= '0;
      shadow_csum_r <= 8'h00;
      fail_cnt_r    <= 4'd0;
      sdata_ready   <= 1'b0;
      key_out       <= '0;
      key_valid     <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      locked_out    <= 1'b0;
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_start) begin
            state_r       <= SHIFT_KEY;
            bit_cnt_r     <= '0;
            shadow_key_r  <= '0;
            shadow_csum_r <= 8'h00;
            sdata_ready   <= 1'b1;
          end else begin
            sdata_ready   <= 1'b0;
          end
        end
        SHIFT_KEY: begin
          if (load_start) begin
            // restart; any bit offered this cycle is dropped
            bit_cnt_r     <= '0;
            shadow_key_r  <= '0;
            shadow_csum_r <= 8'h00;
            sdata_ready   <= 1'b1;
          end else if (hs_s) begin
            shadow_key_r <= {shadow_key_r[KEY_W-2:0], sdata};
            if (bit_cnt_r == LAST_KEY_BIT) begin
              bit_cnt_r <= '0;
              state_r   <= SHIFT_CSUM;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end else begin
            bit_cnt_r <= bit_cnt_r;
          end
        end
        SHIFT_CSUM: begin
          if (load_start) begin
            state_r       <= SHIFT_KEY;
            bit_cnt_r     <= '0;
            shadow_key_r  <= '0;
            shadow_csum_r <= 8'h00;
            sdata_ready   <= 1'b1;
          end else if (bit_cnt_r == CSUM_FULL) begin
            state_r     <= CHECK;
            sdata_ready <= 1'b0;
          end else if (hs_s) begin
            shadow_csum_r <= {shadow_csum_r[6:0], sdata};
            bit_cnt_r     <= bit_cnt_r + CNT_W'(1);
            if (bit_cnt_r == LAST_CSUM_BIT) begin
              sdata_ready <= 1'b0;
            end else begin
              sdata_ready <= 1'b1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r;
          end
        end
        CHECK: begin
          sdata_ready <= 1'b0;
          if (csum_ok_s) begin
            key_out    <= shadow_key_r;
            key_valid  <= 1'b1;
            load_done  <= 1'b1;
            fail_cnt_r <= 4'd0;
            state_r    <= IDLE;
          end else if (fail_cnt_r >= (FAIL_LIMIT - 4'd1)) begin
            load_err   <= 1'b1;
            fail_cnt_r <= FAIL_LIMIT;
            key_out    <= '0;
            key_valid  <= 1'b0;
            locked_out <= 1'b1;
            state_r    <= LOCKOUT;
          end else begin
            load_err   <= 1'b1;
            fail_cnt_r <= fail_cnt_r + 4'd1;
            state_r    <= IDLE;
          end
        end
        LOCKOUT: begin
          sdata_ready <= 1'b0;
          locked_out  <= 1'b1;
          key_out     <= '0;
          key_valid   <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          sdata_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_stream_loader.sv
// Self-checking bench for key_stream_loader: directed frames from the test plan
// plus randomized frames, checked against a frame-level reference model.
module tb_key_stream_loader;

  localparam int KEY_W    = 32;
  localparam int MAX_FAIL = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic              sdata_valid = 1'b0;
  logic              sdata = 1'b0;
  logic              sdata_ready;
  logic [KEY_W-1:0]  key_out;
  logic              key_valid;
  logic              load_done;
  logic              load_err;
  logic              locked_out;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state (frame level)
  logic [31:0] m_key;
  logic        m_valid;
  logic        m_locked;
  int          m_fail;

  key_stream_loader #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .sdata_valid(sdata_valid), .sdata(sdata), .sdata_ready(sdata_ready),
    .key_out(key_out), .key_valid(key_valid), .load_done(load_done),
    .load_err(load_err), .locked_out(locked_out)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_csum(input logic [31:0] k);
    return 8'((k >> 24) ^ (k >> 16) ^ (k >> 8) ^ k);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("reset_outputs",
             {31'd0, key_out, key_valid, load_done, load_err, locked_out, sdata_ready}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_key = 32'd0; m_valid = 1'b0; m_locked = 1'b0; m_fail = 0;
  endtask

  // load_start pulse with a junk bit offered in the same cycle
  task automatic pulse_start();
    load_start  = 1'b1;
    sdata_valid = 1'b1;
    sdata       = 1'($urandom);
    @(negedge clk);
    load_start  = 1'b0;
    sdata_valid = 1'b0;
  endtask

  // send the first nbits of frame (MSB first) with random valid gaps
  task automatic shift_bits(input logic [39:0] frame, input int nbits, input int gap_pct);
    int   sent  = 0;
    int   guard = 0;
    logic hs;
    while (sent < nbits && guard < 4000) begin
      if ($urandom_range(99) < gap_pct) begin
        sdata_valid = 1'b0;
        sdata       = 1'($urandom);
      end else begin
        sdata_valid = 1'b1;
        sdata       = frame[39 - sent];
      end
      hs = sdata_valid & sdata_ready;
      @(negedge clk);
      if (hs) sent++;
      guard++;
    end
    sdata_valid = 1'b0;
    check_eq("handshake_count", 64'(sent), 64'(nbits));
  endtask

  task automatic full_frame(input logic [31:0] key, input logic [7:0] cs, input int gap_pct);
    logic [31:0] pk;
    logic        pv;
    logic        ed;
    logic        ee;
    pk = m_key;
    pv = m_valid;
    pulse_start();
    shift_bits({key, cs}, 40, gap_pct);
    if (cs == ref_csum(key)) begin
      ed = 1'b1; ee = 1'b0;
      m_key = key; m_valid = 1'b1; m_fail = 0;
    end else begin
      ed = 1'b0; ee = 1'b1;
      m_fail++;
      if (m_fail >= MAX_FAIL) begin
        m_locked = 1'b1; m_key = 32'd0; m_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("early_pulses", {62'd0, load_done, load_err}, 64'd0);
    check_eq("key_held", 64'(key_out), 64'(pk));
    check_eq("valid_held", 64'(key_valid), 64'(pv));
    check_eq("ready_low_check", 64'(sdata_ready), 64'd0);
    @(negedge clk);
    check_eq("load_done", 64'(load_done), 64'(ed));
    check_eq("load_err", 64'(load_err), 64'(ee));
    check_eq("key_out", 64'(key_out), 64'(m_key));
    check_eq("key_valid", 64'(key_valid), 64'(m_valid));
    check_eq("locked_out", 64'(locked_out), 64'(m_locked));
    @(negedge clk);
    check_eq("pulse_width", {62'd0, load_done, load_err}, 64'd0);
  endtask

  // while locked, a complete frame must be ignored entirely
  task automatic blocked_frame();
    int bad = 0;
    pulse_start();
    for (int i = 0; i < 45; i++) begin
      sdata_valid = 1'b1;
      sdata       = 1'($urandom);
      @(negedge clk);
      if (sdata_ready || load_done || load_err) bad++;
    end
    sdata_valid = 1'b0;
    check_eq("locked_ignores", 64'(bad), 64'd0);
    check_eq("locked_sticky", 64'(locked_out), 64'd1);
    check_eq("locked_key", {31'd0, key_out, key_valid}, 64'd0);
  endtask

  initial begin
    logic [31:0] rk;
    logic [7:0]  rc;
    m_key = 32'd0; m_valid = 1'b0; m_locked = 1'b0; m_fail = 0;
    #12;
    do_reset();

    // good load, then bad checksum with previous key held
    full_frame(32'hDEADBEEF, 8'h22, 0);
    full_frame(32'h12345678, 8'h00, 0);

    // lockout: two more consecutive failures reach MAX_FAIL
    full_frame(32'hCAFEF00D, 8'h00, 0);
    full_frame(32'h0F0F0F0F, 8'h01, 0);
    blocked_frame();
    do_reset();

    // stalls
    full_frame(32'h0000FFFF, 8'h00, 40);

    // abort after 17 key bits, then a clean frame
    pulse_start();
    shift_bits({32'h5A5A0F0F, 8'h33}, 17, 0);
    full_frame(32'hA5A5A5A5, 8'h00, 0);

    // abort during the checksum phase
    pulse_start();
    shift_bits({32'h11111111, 8'h77}, 36, 10);
    full_frame(32'h01020304, 8'h04, 20);

    // failure counter cleared by a good frame
    full_frame(32'h12345678, 8'h00, 0);
    full_frame(32'h87654321, 8'hFF, 0);
    full_frame(32'hDEADBEEF, 8'h22, 0);
    full_frame(32'h12345678, 8'h00, 0);
    full_frame(32'h87654321, 8'hFF, 0);
    full_frame(32'h00000000, 8'h00, 0);

    // reset mid-frame, then a good frame
    pulse_start();
    shift_bits({32'hDEADBEEF, 8'h22}, 20, 0);
    do_reset();
    full_frame(32'hDEADBEEF, 8'h22, 10);

    // randomized frames
    for (int i = 0; i < 30; i++) begin
      rk = $urandom;
      rc = ref_csum(rk);
      if ($urandom_range(1) == 0) rc = rc ^ 8'($urandom_range(1, 255));
      if ($urandom_range(3) == 0) begin
        pulse_start();
        shift_bits({$urandom, 8'($urandom)}, $urandom_range(1, 39), 20);
      end
      full_frame(rk, rc, $urandom_range(40));
      if (m_locked) begin
        blocked_frame();
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_stream_loader.md
Name: key_stream_loader

Overview:
- Bit-serial key provisioning controller that feeds the keyinput bus of our locked benchmark netlists (e.g. a 32-key c432 variant).
- Receives a framed key (KEY_W key bits followed by an 8-bit checksum) over a valid/ready serial link and verifies the checksum.
- Commits the key onto a held-stable parallel key bus only when the checksum passes.
- Counts failed loads and enters a permanent lockout after MAX_FAIL consecutive failures. Only reset clears lockout.

Parameters:
- KEY_W, 32, key width in bits; must be a multiple of 8, minimum 8.
- MAX_FAIL, 3, consecutive checksum failures that trigger lockout; range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  single-cycle pulse; begins or restarts a frame.
- sdata_valid  input  1  serial bit valid.
- sdata  input  1  serial data bit, MSB first.
- sdata_ready  output  1  loader accepts a bit this cycle.
- key_out  output  KEY_W  committed key, driven to the locked netlist's keyinput bus.
- key_valid  output  1  key_out holds a verified key.
- load_done  output  1  one-cycle pulse on successful commit.
- load_err  output  1  one-cycle pulse on checksum failure.
- locked_out  output  1  lockout reached; sticky until reset.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0, all of these are 0: key_out, key_valid, load_done, load_err, locked_out, sdata_ready, fail counter, bit counter, shadow registers. State is IDLE.
- All outputs are registered. No combinational path from inputs to outputs.
- States are IDLE, SHIFT_KEY, SHIFT_CSUM, CHECK, LOCKOUT.
- IDLE:
  - sdata_ready=0.
  - load_start=1 -> SHIFT_KEY. Bit counter and shadow registers clear.
- SHIFT_KEY:
  - sdata_ready=1.
  - Each handshake (sdata_valid & sdata_ready) shifts sdata into the LSB of the shadow key; the first bit received ends up as key[KEY_W-1].
  - After KEY_W handshakes -> SHIFT_CSUM.
  - Cycles with sdata_valid=0 are stalls with no state change and no timeout.
- SHIFT_CSUM:
  - Same shifting into an 8-bit shadow checksum, MSB first.
  - After 8 handshakes -> CHECK. sdata_ready drops to 0 in CHECK.
- CHECK (exactly one cycle):
  - Expected checksum = XOR of all KEY_W/8 bytes of the shadow key.
  - Match: on the exiting edge, key_out <= shadow key, key_valid <= 1, load_done pulses 1 cycle, fail counter clears, state -> IDLE.
  - Mismatch: load_err pulses 1 cycle, fail counter increments, key_out/key_valid unchanged, state -> IDLE.
  - Mismatch that makes the fail counter reach MAX_FAIL: go to LOCKOUT instead of IDLE.
- Latency: key_out, load_done and load_err update 2 rising edges after the edge that accepted the last checksum bit.
- LOCKOUT:
  - On entry: key_out <= 0, key_valid <= 0, locked_out <= 1. load_err still pulses on the entry edge.
  - All inputs are ignored and sdata_ready=0.
  - Only rst_n exits.
- Previous committed key:
  - key_out and key_valid are held unchanged throughout any load in progress.
  - They are replaced only by a successful commit, or cleared by LOCKOUT/reset.
- load_start during SHIFT_KEY or SHIFT_CSUM:
  - Aborts the frame and restarts at SHIFT_KEY with the counter cleared.
  - No load_err and no fail count.
  - A bit handshake in the same cycle is discarded.
- load_start during CHECK is ignored.
- sdata_valid in IDLE, CHECK or LOCKOUT is ignored; no bits are captured.
- Reset asserted mid-frame clears everything immediately; the partial frame is lost.
- The fail counter saturates at MAX_FAIL and is 4 bits wide.

Test Plan:
- Good load:
  - After reset, pulse load_start, send key 0xDEADBEEF MSB first, then checksum 0x22, sdata_valid continuous.
  - Required: load_done pulses exactly 2 edges after the last bit; key_out=0xDEADBEEF; key_valid=1; load_err never set.
- Bad checksum with previous key held:
  - After the good load, send key 0x12345678 with checksum 0x00 (correct value is 0x08).
  - Required: load_err pulses once; key_out stays 0xDEADBEEF; key_valid stays 1.
- Lockout:
  - Three consecutive bad frames with MAX_FAIL=3.
  - Required: load_err pulses on the third frame; key_out=0 and key_valid=0 on the same edge; locked_out=1; sdata_ready stays 0 and a further good frame is ignored.
  - Then assert rst_n=0 -> locked_out=0 asynchronously.
- Stall and restart:
  - Insert random sdata_valid=0 gaps in a frame for key 0x0000FFFF (checksum 0x00) -> commits correctly.
  - Separately, pulse load_start after 17 key bits, then send a full valid frame for 0xA5A5A5A5 (checksum 0x00) -> only 0xA5A5A5A5 commits; no load_err.
- Failure-counter clear:
  - Two bad frames, then one good frame, then two bad frames.
  - Required: no lockout; locked_out remains 0.
- Reset mid-frame:
  - Drop rst_n after 20 key bits.
  - Required: all outputs read 0 immediately; the next full good frame commits normally.
